f1_light_sequencer: RTL and testbench

Controller that sequences an F1-style start-light run and measures reaction time. It lights N_LIGHTS lamps one per tick, then fires the random-delay block (trigger/time_out handshake). When that delay expires it extinguishes all lamps and counts clock cycles until the player reacts. It sits between the 1-tick clock divider, the random delay unit, the LED bar and the reaction-time display.

---
 rtl/f1_light_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_f1_light_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f1_light_sequencer.sv
// F1 start-light sequencer: lights lamps one per tick, arms a random delay, times the player's reaction.
// Latency: every input is sampled at a rising clk edge and its effect appears on the registered outputs one cycle later.
// Backpressure: none; tick, delay_done and react are plain sampled strobes/levels, start is ignored while busy.
//
// Ports:
//   clk, rst      - sole clock; synchronous active-high reset
//   start         - level; begins a run when sampled high in IDLE
//   tick          - one-cycle pacing pulse from the clock divider
//   react         - synchronised, debounced player button
//   delay_done    - time-out pulse from the random delay block
//   delay_start   - one-cycle trigger pulse to the random delay block
//   data_out      - lamp bar, bit i = lamp i (bits N_LIGHTS..7 always 0)
//   busy          - high in every state except IDLE
//   react_valid   - one-cycle pulse, react_time has just been updated
//   react_time    - last measured reaction time in clk cycles
//   false_start   - one-cycle pulse, react seen before the lamps went out
module f1_light_sequencer #(
    parameter int N_LIGHTS  = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 tick,
    input  logic                 react,
    input  logic                 delay_done,
    output logic                 delay_start,
    output logic [7:0]           data_out,
    output logic                 busy,
    output logic                 react_valid,
    output logic [CNT_WIDTH-1:0] react_time,
    output logic                 false_start
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LIGHTS = 3'd1,
        S_DELAY  = 3'd2,
        S_REACT  = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    // Only the lowest N_LIGHTS lamps may ever be lit.
    localparam logic [7:0]           LAMP_MASK = 8'((1 << N_LIGHTS) - 1);
    localparam logic [3:0]           N_LAMPS   = 4'(N_LIGHTS);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    state_t               state_q,       state_d;
    logic [3:0]           lamp_cnt_q,    lamp_cnt_d;
    logic [7:0]           data_out_q,    data_out_d;
    logic                 busy_q,        busy_d;
    logic                 delay_start_q, delay_start_d;
    logic                 react_valid_q, react_valid_d;
    logic                 false_start_q, false_start_d;
    logic [CNT_WIDTH-1:0] react_time_q,  react_time_d;
    logic [CNT_WIDTH-1:0] react_cnt_q,   react_cnt_d;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LIGHTS;
                end
            end
            S_LIGHTS: begin
                // A premature press aborts the run even if a tick arrives in the same cycle.
                if (react) begin
                    state_d = S_IDLE;
                end else if (tick && (lamp_cnt_q == N_LAMPS)) begin
                    state_d = S_DELAY;
                end
            end
            S_DELAY: begin
                // delay_done is masked while our own trigger pulse is still on the wire,
                // so a stale time-out from the delay block cannot end the wait instantly.
                if (react) begin
                    state_d = S_IDLE;
                end else if (delay_done && !delay_start_q) begin
                    state_d = S_REACT;
                end
            end
            S_REACT: begin
                if (react) begin
                    state_d = S_RESULT;
                end
            end
            S_RESULT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output / datapath logic: next values for the registered outputs and counters.
    always_comb begin
        lamp_cnt_d    = lamp_cnt_q;
        data_out_d    = data_out_q;
        delay_start_d = 1'b0;
        react_valid_d = 1'b0;
        false_start_d = 1'b0;
        react_time_d  = react_time_q;
        react_cnt_d   = react_cnt_q;
        busy_d        = (state_d != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    lamp_cnt_d = 4'd1;
                    data_out_d = 8'h01 & LAMP_MASK;
                end
            end
            S_LIGHTS: begin
                if (react) begin
                    false_start_d = 1'b1;
                    data_out_d    = 8'h00;
                    lamp_cnt_d    = 4'd0;
                end else if (tick) begin
                    if (lamp_cnt_q < N_LAMPS) begin
                        lamp_cnt_d = lamp_cnt_q + 4'd1;
                        data_out_d = ((data_out_q << 1) | 8'h01) & LAMP_MASK;
                    end else begin
                        // All lamps lit: bar holds, delay block is triggered.
                        delay_start_d = 1'b1;
                    end
                end
            end
            S_DELAY: begin
                if (react) begin
                    false_start_d = 1'b1;
                    data_out_d    = 8'h00;
                    lamp_cnt_d    = 4'd0;
                end else if (delay_done && !delay_start_q) begin
                    // Lights out: the reaction clock starts from zero.
                    data_out_d  = 8'h00;
                    lamp_cnt_d  = 4'd0;
                    react_cnt_d = '0;
                end
            end
            S_REACT: begin
                if (react) begin
                    react_time_d  = react_cnt_q;
                    react_valid_d = 1'b1;
                end else if (react_cnt_q != CNT_MAX) begin
                    // Saturate rather than wrap so a very slow player never reads as fast.
                    react_cnt_d = react_cnt_q + 1'b1;
                end
            end
            S_RESULT: begin
                data_out_d = 8'h00;
            end
            default: begin
                data_out_d = 8'h00;
                lamp_cnt_d = 4'd0;
            end
        endcase
    end

    // Registered outputs and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            lamp_cnt_q    <= 4'd0;
            data_out_q    <= 8'h00;
            busy_q        <= 1'b0;
            delay_start_q <= 1'b0;
            react_valid_q <= 1'b0;
            false_start_q <= 1'b0;
            react_time_q  <= '0;
            react_cnt_q   <= '0;
        end else begin
            lamp_cnt_q    <= lamp_cnt_d;
            data_out_q    <= data_out_d;
            busy_q        <= busy_d;
            delay_start_q <= delay_start_d;
            react_valid_q <= react_valid_d;
            false_start_q <= false_start_d;
            react_time_q  <= react_time_d;
            react_cnt_q   <= react_cnt_d;
        end
    end

    assign data_out    = data_out_q;
    assign busy        = busy_q;
    assign delay_start = delay_start_q;
    assign react_valid = react_valid_q;
    assign false_start = false_start_q;
    assign react_time  = react_time_q;

endmodule

// File: tb/tb_f1_light_sequencer.sv
// Testbench for f1_light_sequencer: directed runs on an 8-lamp/16-bit instance and a 1-lamp/4-bit instance.
// Run-ending events (react_valid / false_start) are predicted into queues and checked by monitors.
// Lamp bar, busy and delay_start are checked directly one ns after the relevant edge.
module tb_f1_light_sequencer;

    logic        clk = 1'b0;
    logic        rst;

    // 8-lamp, 16-bit instance
    logic        start, tick, react, delay_done;
    logic        delay_start, busy, react_valid, false_start;
    logic [7:0]  data_out;
    logic [15:0] react_time;

    // 1-lamp, 4-bit instance
    logic        s_start, s_tick, s_react, s_delay_done;
    logic        s_delay_start, s_busy, s_react_valid, s_false_start;
    logic [7:0]  s_data_out;
    logic [3:0]  s_react_time;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        fs;
        logic [15:0] t;
    } ev_t;

    ev_t exp_q[$];
    ev_t exp4_q[$];

    always #5 clk = ~clk;

    f1_light_sequencer #(.N_LIGHTS(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .tick(tick), .react(react),
        .delay_done(delay_done), .delay_start(delay_start), .data_out(data_out),
        .busy(busy), .react_valid(react_valid), .react_time(react_time),
        .false_start(false_start)
    );

    f1_light_sequencer #(.N_LIGHTS(1), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(s_start), .tick(s_tick), .react(s_react),
        .delay_done(s_delay_done), .delay_start(s_delay_start), .data_out(s_data_out),
        .busy(s_busy), .react_valid(s_react_valid), .react_time(s_react_time),
        .false_start(s_false_start)
    );

    // Monitor for the 8-lamp instance.
    always @(negedge clk) begin
        ev_t e;
        if (!rst && (react_valid || false_start)) begin
            checks++;
            if (react_valid && false_start) begin
                errors++;
                $display("FAIL both_pulses: react_valid=%0b false_start=%0b, required never both", react_valid, false_start);
            end
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: react_valid=%0b false_start=%0b react_time=%0d, none expected",
                         react_valid, false_start, react_time);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (e.fs != false_start || e.fs == react_valid || e.t != react_time) begin
                    errors++;
                    $display("FAIL run_result: got fs=%0b rv=%0b time=%0d, required fs=%0b rv=%0b time=%0d",
                             false_start, react_valid, react_time, e.fs, !e.fs, e.t);
                end
            end
        end
    end

    // Monitor for the 1-lamp, 4-bit instance.
    always @(negedge clk) begin
        ev_t e;
        if (!rst && (s_react_valid || s_false_start)) begin
            checks++;
            if (exp4_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event4: react_valid=%0b false_start=%0b react_time=%0d, none expected",
                         s_react_valid, s_false_start, s_react_time);
            end else begin
                e = exp4_q.pop_front();
                if (e.fs != s_false_start || e.fs == s_react_valid || e.t != {12'd0, s_react_time}) begin
                    errors++;
                    $display("FAIL run_result4: got fs=%0b rv=%0b time=%0d, required fs=%0b rv=%0b time=%0d",
                             s_false_start, s_react_valid, s_react_time, e.fs, !e.fs, e.t);
                end
            end
        end
    end

    // Hard time limit in case anything stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    // Start a run, light all 8 lamps and move into DELAY past the trigger cycle.
    task automatic run_to_delay(input logic hold_start);
        start = 1'b1;
        cyc(1);
        start = hold_start;
        for (int i = 0; i < 8; i++) begin
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
            cyc(1);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 0; tick = 0; react = 0; delay_done = 0;
        s_start = 0; s_tick = 0; s_react = 0; s_delay_done = 0;
        cyc(2);
        rst = 1'b0;

        // Reset state
        chk("reset_data_out", 32'(data_out), 32'h00);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_react_time", 32'(react_time), 32'h0);
        chk("reset_delay_start", 32'(delay_start), 32'h0);
        chk("reset_pulses", {30'd0, react_valid, false_start}, 32'h0);

        // Normal run: ticks every 5 cycles, delay_done ignored in LIGHTS
        exp_q.push_back('{fs: 1'b0, t: 16'd100});
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("run_first_lamp", 32'(data_out), 32'h01);
        chk("run_busy", 32'(busy), 32'h1);
        for (int i = 1; i <= 8; i++) begin
            cyc(4);
            tick = 1'b1;
            delay_done = (i == 4);
            cyc(1);
            tick = 1'b0;
            delay_done = 1'b0;
            if (i < 8) begin
                chk($sformatf("run_lamps_tick%0d", i), 32'(data_out), (32'd1 << (i + 1)) - 32'd1);
                chk($sformatf("run_no_trigger_tick%0d", i), 32'(delay_start), 32'h0);
            end else begin
                chk("run_delay_start", 32'(delay_start), 32'h1);
                chk("run_lamps_full", 32'(data_out), 32'hFF);
            end
        end
        // delay_done in the trigger cycle must be ignored
        delay_done = 1'b1;
        cyc(1);
        delay_done = 1'b0;
        chk("run_delay_start_one_cycle", 32'(delay_start), 32'h0);
        cyc(19);
        chk("run_still_delay", 32'(data_out), 32'hFF);
        delay_done = 1'b1;
        cyc(1);
        delay_done = 1'b0;
        chk("run_lamps_out", 32'(data_out), 32'h00);
        cyc(100);
        react = 1'b1;
        cyc(1);
        react = 1'b0;
        chk("run_result_busy", 32'(busy), 32'h1);
        cyc(1);
        chk("run_idle_busy", 32'(busy), 32'h0);
        chk("run_valid_one_cycle", 32'(react_valid), 32'h0);

        // False start at 3 lamps, react_time keeps 100
        exp_q.push_back('{fs: 1'b1, t: 16'd100});
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        repeat (2) begin
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
        end
        chk("fs_lamps", 32'(data_out), 32'h07);
        react = 1'b1;
        cyc(1);
        react = 1'b0;
        chk("fs_data_out", 32'(data_out), 32'h00);
        chk("fs_busy", 32'(busy), 32'h0);
        chk("fs_react_time_kept", 32'(react_time), 32'd100);
        cyc(1);
        chk("fs_one_cycle", 32'(false_start), 32'h0);

        // react and delay_done together in DELAY: false start wins
        exp_q.push_back('{fs: 1'b1, t: 16'd100});
        run_to_delay(1'b0);
        chk("prio_in_delay", 32'(data_out), 32'hFF);
        react = 1'b1;
        delay_done = 1'b1;
        cyc(1);
        react = 1'b0;
        delay_done = 1'b0;
        chk("prio_data_out", 32'(data_out), 32'h00);
        cyc(3);
        chk("prio_no_react_state", 32'(busy), 32'h0);

        // Reset mid-REACT with counter at 37
        run_to_delay(1'b0);
        delay_done = 1'b1;
        cyc(1);
        delay_done = 1'b0;
        cyc(37);
        chk("rst_mid_busy_before", 32'(busy), 32'h1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_data_out", 32'(data_out), 32'h00);
        chk("rst_mid_react_time", 32'(react_time), 32'h0);
        chk("rst_mid_pulses", {29'd0, delay_start, react_valid, false_start}, 32'h0);

        // start held high: second start in LIGHTS has no effect, runs go back-to-back
        exp_q.push_back('{fs: 1'b0, t: 16'd0});
        start = 1'b1;
        cyc(1);
        cyc(3);
        chk("held_start_no_restart", 32'(data_out), 32'h01);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        chk("held_start_advance", 32'(data_out), 32'h03);
        for (int i = 0; i < 7; i++) begin
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
            cyc(1);
        end
        delay_done = 1'b1;
        cyc(1);
        delay_done = 1'b0;
        react = 1'b1;            // react in the first REACT cycle
        cyc(1);
        react = 1'b0;            // RESULT cycle
        cyc(1);
        chk("held_idle_busy", 32'(busy), 32'h0);
        chk("held_idle_data", 32'(data_out), 32'h00);
        cyc(1);
        chk("held_restart_busy", 32'(busy), 32'h1);
        chk("held_restart_data", 32'(data_out), 32'h01);
        start = 1'b0;
        exp_q.push_back('{fs: 1'b1, t: 16'd0});
        react = 1'b1;
        cyc(1);
        react = 1'b0;
        cyc(1);

        // 1 lamp, 4-bit counter: first tick goes to DELAY, counter saturates at 15
        exp4_q.push_back('{fs: 1'b0, t: 16'h000F});
        s_start = 1'b1;
        cyc(1);
        s_start = 1'b0;
        chk("n1_first_lamp", 32'(s_data_out), 32'h01);
        s_tick = 1'b1;
        cyc(1);
        s_tick = 1'b0;
        chk("n1_delay_start", 32'(s_delay_start), 32'h1);
        chk("n1_lamps_held", 32'(s_data_out), 32'h01);
        cyc(1);
        s_delay_done = 1'b1;
        cyc(1);
        s_delay_done = 1'b0;
        chk("n1_lamps_out", 32'(s_data_out), 32'h00);
        cyc(40);
        s_react = 1'b1;
        cyc(1);
        s_react = 1'b0;
        chk("sat_react_time", 32'(s_react_time), 32'hF);
        cyc(2);
        chk("sat_idle", 32'(s_busy), 32'h0);

        // Every predicted event must have been observed
        cyc(3);
        chk("events_drained", 32'(exp_q.size()), 32'd0);
        chk("events4_drained", 32'(exp4_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $finish;
    end

endmodule
